// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers for the pipelined adder tree and its group accumulator.
package adder_tree_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int tree_levels(input int num_inputs);
    return clog2(num_inputs);
  endfunction

  // Lane width inside the tree: wide enough that no level can overflow.
  function automatic int tree_width(input int data_width, input int num_inputs);
    return data_width + tree_levels(num_inputs);
  endfunction

  function automatic int tree_ranks(input int levels, input int reg_every);
    return (levels + reg_every - 1) / reg_every;
  endfunction

  function automatic bit rank_after(input int level, input int levels, input int reg_every);
    return ((level % reg_every) == 0) || (level == levels);
  endfunction

  function automatic bit cfg_ok(input int data_width, input int num_inputs,
                                input int out_width, input int reg_every);
    return (num_inputs >= 2) && (reg_every >= 1) &&
           (out_width >= tree_width(data_width, num_inputs));
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One level of pairwise adds; optionally followed by a pipeline register rank.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int TW   = 23,
  parameter int N_IN = 2,
  parameter bit REG  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [N_IN*TW-1:0]       in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic [(N_IN/2)*TW-1:0]   out_data,
  output logic                     out_valid,
  output logic                     out_last
);

  localparam int N_OUT = N_IN / 2;

  logic [N_OUT*TW-1:0] sums;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sums = '0;
    for (int j = 0; j < N_OUT; j++) begin
      sums[j*TW +: TW] = in_data[(2*j)*TW +: TW] + in_data[(2*j+1)*TW +: TW];
    end
  end

  if (REG) begin : g_reg
    // NOTE: data registers are reset too, so a flushed pipeline shows zeros, not stale sums.
    // NOTE: sequential state uses non-blocking assignments so all ranks shift on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_data  <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (en) begin
        out_data  <= sums;
        out_valid <= in_valid;
        out_last  <= in_last;
      end
    end
  end else begin : g_comb
    assign out_data  = sums;
    assign out_valid = in_valid;
    assign out_last  = in_last;

    // Control inputs only matter for registered levels.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst_n, en};
  end

endmodule

// File: rtl/adder_tree_acc.sv
// Handshaked, pipelined adder tree feeding a saturating/wrapping group accumulator.
module adder_tree_acc
  import adder_tree_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 128,
  parameter int OUT_WIDTH  = 32,
  parameter int REG_EVERY  = 2,
  parameter int SIGNED     = 1,
  parameter int SAT        = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic                             in_valid,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic [OUT_WIDTH-1:0]             out_sum,
  output logic                             out_ovf,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int LEVELS   = tree_levels(NUM_INPUTS);
  localparam int TW       = tree_width(DATA_WIDTH, NUM_INPUTS);
  localparam int PADDED   = 1 << LEVELS;
  localparam bit SX       = (SIGNED != 0);
  localparam bit SATURATE = (SAT != 0);
  localparam int MSB      = OUT_WIDTH - 1;

  localparam logic [OUT_WIDTH-1:0] EXT_MASK = {OUT_WIDTH{1'b1}} << TW;
  localparam logic [OUT_WIDTH-1:0] S_MIN    = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] S_MAX    = ~S_MIN;

  if (!cfg_ok(DATA_WIDTH, NUM_INPUTS, OUT_WIDTH, REG_EVERY)) begin : g_cfg_check
    $error("adder_tree_acc: illegal parameter combination");
  end

  // The whole pipeline stalls as one while a result waits for downstream.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Lanes widened to TW; missing lanes up to the power of two stay zero.
  logic [PADDED*TW-1:0] ext_data;

  always_comb begin
    ext_data = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      ext_data[i*TW +: TW] =
        {{(TW-DATA_WIDTH){SX & in_data[i*DATA_WIDTH + DATA_WIDTH - 1]}},
         in_data[i*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int N_IN = PADDED >> (k - 1);

    logic [N_IN*TW-1:0]       src_data;
    logic                     src_valid;
    logic                     src_last;
    logic [(N_IN/2)*TW-1:0]   data;
    logic                     valid;
    logic                     last;

    if (k == 1) begin : g_src_in
      assign src_data  = ext_data;
      assign src_valid = in_valid;
      assign src_last  = in_last;
    end else begin : g_src_prev
      assign src_data  = g_lvl[k-1].data;
      assign src_valid = g_lvl[k-1].valid;
      assign src_last  = g_lvl[k-1].last;
    end

    adder_tree_level #(
      .TW   (TW),
      .N_IN (N_IN),
      .REG  (rank_after(k, LEVELS, REG_EVERY))
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_data   (src_data),
      .in_valid  (src_valid),
      .in_last   (src_last),
      .out_data  (data),
      .out_valid (valid),
      .out_last  (last)
    );
  end

  logic [TW-1:0]        tree_sum;
  logic                 tree_valid;
  logic                 tree_last;
  logic [OUT_WIDTH-1:0] t_ext;
  logic [OUT_WIDTH:0]   sum_wide;
  logic [OUT_WIDTH-1:0] add_res;
  logic                 add_ovf;
  logic [OUT_WIDTH-1:0] acc_next;
  logic                 group_start;

  assign tree_sum   = g_lvl[LEVELS].data;
  assign tree_valid = g_lvl[LEVELS].valid;
  assign tree_last  = g_lvl[LEVELS].last;

  always_comb begin
    t_ext    = OUT_WIDTH'(tree_sum) | ((SX && tree_sum[TW-1]) ? EXT_MASK : '0);
    sum_wide = {1'b0, out_sum} + {1'b0, t_ext};
    add_res  = sum_wide[OUT_WIDTH-1:0];
    // Signed overflow: operands agree in sign but the result does not.
    if (SX) add_ovf = (out_sum[MSB] == t_ext[MSB]) && (add_res[MSB] != out_sum[MSB]);
    else    add_ovf = sum_wide[OUT_WIDTH];
    acc_next = add_res;
    if (SATURATE && add_ovf) begin
      if (SX) acc_next = out_sum[MSB] ? S_MIN : S_MAX;
      else    acc_next = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum     <= '0;
      out_ovf     <= 1'b0;
      out_valid   <= 1'b0;
      group_start <= 1'b1;
    end else if (en) begin
      // A fresh beat right after a closed group starts the next one at full rate.
      out_valid <= tree_valid && tree_last;
      if (tree_valid) begin
        group_start <= tree_last;
        if (group_start) begin
          out_sum <= t_ext;
          out_ovf <= 1'b0;
        end else begin
          out_sum <= acc_next;
          out_ovf <= out_ovf | add_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Scoreboard bench: five configurations of adder_tree_acc fed the same beat stream.
module tb_adder_tree_acc;

  typedef struct packed {
    logic [31:0] sum;
    logic        ovf;
  } exp_t;

  // Per-instance configuration used by the reference model.
  localparam int CFG_N   [5] = '{128, 128, 128, 128, 100};
  localparam int CFG_OW  [5] = '{32, 24, 24, 32, 32};
  localparam int CFG_SGN [5] = '{1, 1, 1, 0, 1};
  localparam int CFG_SAT [5] = '{1, 1, 0, 1, 1};

  logic            clk;
  logic            rst_n;
  logic [2047:0]   in_data;
  logic            in_valid;
  logic            in_last;
  logic            out_ready;
  logic            ir0;
  logic            vg;
  logic [4:1]      ir_s;
  logic [4:0]      ov;
  logic [4:0]      ovf;
  logic [31:0]     sum0;
  logic [23:0]     sum1;
  logic [23:0]     sum2;
  logic [31:0]     sum3;
  logic [31:0]     sum4;
  logic [31:0]     sums [5];

  int   n_checks;
  int   n_errors;
  exp_t q [5][$];
  longint acc_m [5];
  bit   ovf_m [5];
  bit   start_m [5];

  // Secondary instances never stall, so they accept exactly the beats u0 accepts.
  assign vg = in_valid & ir0;
  assign sums[0] = sum0;
  assign sums[1] = {8'h00, sum1};
  assign sums[2] = {8'h00, sum2};
  assign sums[3] = sum3;
  assign sums[4] = sum4;

  adder_tree_acc u0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(ir0), .out_sum(sum0), .out_ovf(ovf[0]), .out_valid(ov[0]), .out_ready(out_ready));

  adder_tree_acc #(.OUT_WIDTH(24), .SAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(vg), .in_last(in_last),
    .in_ready(ir_s[1]), .out_sum(sum1), .out_ovf(ovf[1]), .out_valid(ov[1]), .out_ready(1'b1));

  adder_tree_acc #(.OUT_WIDTH(24), .SAT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(vg), .in_last(in_last),
    .in_ready(ir_s[2]), .out_sum(sum2), .out_ovf(ovf[2]), .out_valid(ov[2]), .out_ready(1'b1));

  adder_tree_acc #(.SIGNED(0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(vg), .in_last(in_last),
    .in_ready(ir_s[3]), .out_sum(sum3), .out_ovf(ovf[3]), .out_valid(ov[3]), .out_ready(1'b1));

  adder_tree_acc #(.NUM_INPUTS(100), .REG_EVERY(3)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1599:0]), .in_valid(vg), .in_last(in_last),
    .in_ready(ir_s[4]), .out_sum(sum4), .out_ovf(ovf[4]), .out_valid(ov[4]), .out_ready(1'b1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic model_beat(input int d);
    longint t, r, lo, hi, one, mask;
    logic [15:0] v;
    exp_t e;
    one  = 1;
    t    = 0;
    mask = (one <<< CFG_OW[d]) - 1;
    for (int i = 0; i < CFG_N[d]; i++) begin
      v = in_data[i*16 +: 16];
      if (CFG_SGN[d] != 0) t += longint'($signed(v));
      else                 t += longint'({48'd0, v});
    end
    if (CFG_SGN[d] != 0) begin
      lo = -(one <<< (CFG_OW[d] - 1));
      hi = (one <<< (CFG_OW[d] - 1)) - 1;
    end else begin
      lo = 0;
      hi = mask;
    end
    if (start_m[d]) begin
      acc_m[d] = t;
      ovf_m[d] = 1'b0;
    end else begin
      r = acc_m[d] + t;
      if (r > hi || r < lo) begin
        ovf_m[d] = 1'b1;
        if (CFG_SAT[d] != 0) r = (r > hi) ? hi : lo;
        else begin
          r = r & mask;
          if (CFG_SGN[d] != 0 && r > hi) r -= (one <<< CFG_OW[d]);
        end
      end
      acc_m[d] = r;
    end
    start_m[d] = in_last;
    if (in_last) begin
      e.sum = 32'(acc_m[d] & mask);
      e.ovf = ovf_m[d];
      q[d].push_back(e);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n && in_valid && ir0) begin
      for (int d = 0; d < 5; d++) model_beat(d);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int d = 0; d < 5; d++) begin
        if (ov[d] && (d != 0 || out_ready)) begin
          if (q[d].size() == 0) begin
            check($sformatf("u%0d_spurious_out_valid", d), 32'(ov[d]), 32'd0);
          end else begin
            e = q[d].pop_front();
            check($sformatf("u%0d_out_sum", d), sums[d], e.sum);
            check($sformatf("u%0d_out_ovf", d), 32'(ovf[d]), 32'(e.ovf));
          end
        end
      end
    end
  end

  // mode 0: all lanes v; mode 1: lane i = v + i; otherwise random lanes.
  task automatic send(input int mode, input logic [15:0] v, input bit last);
    bit ok;
    for (int i = 0; i < 128; i++) begin
      case (mode)
        0:       in_data[i*16 +: 16] = v;
        1:       in_data[i*16 +: 16] = v + 16'(i);
        default: in_data[i*16 +: 16] = 16'($urandom);
      endcase
    end
    in_valid = 1'b1;
    in_last  = last;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = ir0;
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int lat0, lat4;
    logic [31:0] held_sum;
    logic        held_ovf;

    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    for (int d = 0; d < 5; d++) begin
      start_m[d] = 1'b1;
      acc_m[d]   = 0;
      ovf_m[d]   = 1'b0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(ov[0]), 32'd0);
    check("rst_out_sum", sum0, 32'd0);
    check("rst_out_ovf", 32'(ovf[0]), 32'd0);
    check("rst_in_ready", 32'(ir0), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat of +1: latency counted in edges from the accepting edge.
    send(0, 16'd1, 1'b1);
    idle();
    lat0 = 0;
    lat4 = 0;
    for (int n = 1; n <= 20 && (lat0 == 0 || lat4 == 0); n++) begin
      if (ov[0] && lat0 == 0) begin
        lat0 = n;
        check("plus1_sum_u0", sum0, 32'd128);
      end
      if (ov[4] && lat4 == 0) begin
        lat4 = n;
        check("plus1_sum_u4", sum4, 32'd100);
      end
      @(posedge clk);
      #1;
    end
    check("latency_u0", 32'(lat0), 32'd5);
    check("latency_u4", 32'(lat4), 32'd4);
    repeat (3) @(posedge clk);
    #1;

    // Sign extension, varied lanes, multi-beat group, overflow group.
    send(0, 16'hFFFF, 1'b1);
    send(1, 16'd0, 1'b1);
    send(1, 16'hFF00, 1'b1);
    send(0, 16'd2, 1'b0);
    send(0, 16'd3, 1'b0);
    send(0, 16'd4, 1'b1);
    send(0, 16'd32767, 1'b0);
    send(0, 16'd32767, 1'b0);
    send(0, 16'd32767, 1'b1);
    // Back-to-back single-beat groups, then random group lengths.
    for (int b = 0; b < 8; b++) send(2, 16'd0, 1'b1);
    for (int b = 0; b < 12; b++) send(2, 16'd0, ($urandom_range(0, 3) == 0));
    send(2, 16'd0, 1'b1);
    idle();
    repeat (10) @(posedge clk);
    #1;

    // Downstream stall while beats stream.
    out_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 8; b++) send(2, 16'd0, 1'b1);
        idle();
      end
      begin
        for (int n = 0; n < 40 && !ov[0]; n++) @(negedge clk);
        check("stall_result_seen", 32'(ov[0]), 32'd1);
        held_sum = sum0;
        held_ovf = ovf[0];
        for (int n = 0; n < 4; n++) begin
          check("stall_out_valid", 32'(ov[0]), 32'd1);
          check("stall_in_ready", 32'(ir0), 32'd0);
          check("stall_out_sum", sum0, held_sum);
          check("stall_out_ovf", 32'(ovf[0]), 32'(held_ovf));
          @(negedge clk);
        end
        check("stall_other_in_ready", 32'(ir_s), 32'hF);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;

    // Reset with two beats in flight discards both.
    send(2, 16'd0, 1'b0);
    send(2, 16'd0, 1'b1);
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    for (int d = 0; d < 5; d++) begin
      q[d].delete();
      start_m[d] = 1'b1;
      acc_m[d]   = 0;
      ovf_m[d]   = 1'b0;
    end
    #2;
    check("midrst_out_valid", 32'(ov[0]), 32'd0);
    check("midrst_out_sum", sum0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send(0, 16'd1, 1'b1);
    idle();
    repeat (12) @(posedge clk);
    #1;

    for (int d = 0; d < 5; d++) check($sformatf("u%0d_pending_results", d), 32'(q[d].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
